// File: rtl/bulls_cows_match.sv
// bulls_cows_match: two-player Bulls & Cows referee.
// Each player stores a secret code, then they alternate guesses against the
// opponent's secret. Every accepted guess is scored as bulls/cows. The game
// ends on a full hit (win) or when both guess budgets are spent (draw).
// Optional feature: define BCM_TURN_TIMEOUT_EN to forfeit a turn after
// TURN_TIMEOUT idle cycles in a guess phase. The default build has no timer.

module bulls_cows_match #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int SYMBOLS      = 10,
    parameter int MAX_GUESSES  = 8,
    parameter int TURN_TIMEOUT = 1000,
    localparam int CODE_W      = NUM_DIGITS * DIGIT_W,
    localparam int CNT_W       = $clog2(NUM_DIGITS + 1),
    localparam int TRY_W       = $clog2(MAX_GUESSES + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              enter,
    input  logic              abort,
    output logic [2:0]        phase,
    output logic [CNT_W-1:0]  bulls,
    output logic [CNT_W-1:0]  cows,
    output logic              last_plyr,
    output logic [TRY_W-1:0]  tries1,
    output logic [TRY_W-1:0]  tries2,
    output logic              accept,
    output logic              reject,
    output logic              timeout,
    output logic              p1_win,
    output logic              p2_win,
    output logic              draw
);

    localparam logic [2:0] PH_SET1   = 3'd0;
    localparam logic [2:0] PH_SET2   = 3'd1;
    localparam logic [2:0] PH_GUESS1 = 3'd2;
    localparam logic [2:0] PH_GUESS2 = 3'd3;
    localparam logic [2:0] PH_SHOW   = 3'd4;
    localparam logic [2:0] PH_DONE   = 3'd5;

    localparam logic [DIGIT_W:0]  SYM_LIM  = (DIGIT_W + 1)'(SYMBOLS);
    localparam logic [CNT_W-1:0]  FULL_HIT = CNT_W'(NUM_DIGITS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [TRY_W-1:0]  TRY_MAX  = TRY_W'(MAX_GUESSES);
    localparam logic [TRY_W-1:0]  TRY_ONE  = TRY_W'(1);

    // Reject parameter sets the datapath cannot represent.
    if (NUM_DIGITS < 2 || MAX_GUESSES < 1 || SYMBOLS > (1 << DIGIT_W) || TURN_TIMEOUT < 2)
    begin : g_param_check
        $error("bulls_cows_match: illegal parameter set");
    end

    logic [CODE_W-1:0] secret1;
    logic [CODE_W-1:0] secret2;
    logic              enter_q;
    logic              armed;
    logic              ent;
    logic              code_ok;
    logic              in_guess;
    logic              cur_p2;
    logic              expire;
    logic [CODE_W-1:0] opp_secret;
    logic [CNT_W-1:0]  sc_bulls;
    logic [CNT_W-1:0]  sc_cows;

    // A legal code uses only symbols below SYMBOLS and never repeats a digit.
    function automatic logic code_valid(input logic [CODE_W-1:0] c);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ({1'b0, c[i*DIGIT_W +: DIGIT_W]} >= SYM_LIM) ok = 1'b0;
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (c[i*DIGIT_W +: DIGIT_W] == c[j*DIGIT_W +: DIGIT_W]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // The budget check in SHOW prevents overflow; saturation is a backstop.
    function automatic logic [TRY_W-1:0] sat_inc(input logic [TRY_W-1:0] t);
        return (t == TRY_MAX) ? t : t + TRY_ONE;
    endfunction

    // armed blocks the first cycle after reset so a held enter is not a command.
    assign ent      = enter & ~enter_q & armed;
    assign code_ok  = code_valid(code_in);
    assign in_guess = (phase == PH_GUESS1) || (phase == PH_GUESS2);
    assign cur_p2   = (phase == PH_GUESS2);
    assign opp_secret = cur_p2 ? secret1 : secret2;

    // Score the presented guess against the opponent's secret every cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path holds a stale value (no latch).
        sc_bulls = '0;
        sc_cows  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (opp_secret[i*DIGIT_W +: DIGIT_W] == code_in[j*DIGIT_W +: DIGIT_W]) begin
                    if (i == j) sc_bulls = sc_bulls + CNT_ONE;
                    else        sc_cows  = sc_cows + CNT_ONE;
                end
            end
        end
    end

`ifdef BCM_TURN_TIMEOUT_EN
    localparam int             TMR_W    = $clog2(TURN_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TURN_TIMEOUT - 1);

    logic [TMR_W-1:0] turn_timer;

    // A command takes precedence over expiry in the same cycle.
    assign expire = in_guess && (turn_timer == TMR_LAST) && !ent;

    // Turn timer: runs only while a player is to guess, restarts on any command.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            turn_timer <= '0;
        end else if (!in_guess || abort || ent || expire) begin
            turn_timer <= '0;
        end else begin
            turn_timer <= turn_timer + TMR_W'(1);
        end
    end
`else
    assign expire = 1'b0;
`endif

    // Game controller: command edge detect, phase sequencing and scoring registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enter_q   <= 1'b0;
            armed     <= 1'b0;
            phase     <= PH_SET1;
            secret1   <= '0;
            secret2   <= '0;
            bulls     <= '0;
            cows      <= '0;
            last_plyr <= 1'b0;
            tries1    <= '0;
            tries2    <= '0;
            accept    <= 1'b0;
            reject    <= 1'b0;
            timeout   <= 1'b0;
            p1_win    <= 1'b0;
            p2_win    <= 1'b0;
            draw      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            enter_q <= enter;
            armed   <= 1'b1;
            accept  <= 1'b0;
            reject  <= 1'b0;
            timeout <= 1'b0;

            if (abort || (ent && phase == PH_DONE)) begin
                phase     <= PH_SET1;
                secret1   <= '0;
                secret2   <= '0;
                bulls     <= '0;
                cows      <= '0;
                last_plyr <= 1'b0;
                tries1    <= '0;
                tries2    <= '0;
                p1_win    <= 1'b0;
                p2_win    <= 1'b0;
                draw      <= 1'b0;
            end else if (ent) begin
                case (phase)
                    PH_SET1: begin
                        if (code_ok) begin
                            secret1 <= code_in;
                            accept  <= 1'b1;
                            phase   <= PH_SET2;
                        end else begin
                            reject  <= 1'b1;
                        end
                    end
                    PH_SET2: begin
                        if (code_ok) begin
                            secret2 <= code_in;
                            accept  <= 1'b1;
                            phase   <= PH_GUESS1;
                        end else begin
                            reject  <= 1'b1;
                        end
                    end
                    PH_GUESS1, PH_GUESS2: begin
                        if (code_ok) begin
                            bulls     <= sc_bulls;
                            cows      <= sc_cows;
                            last_plyr <= cur_p2;
                            accept    <= 1'b1;
                            if (cur_p2) tries2 <= sat_inc(tries2);
                            else        tries1 <= sat_inc(tries1);
                            if (sc_bulls == FULL_HIT) begin
                                if (cur_p2) p2_win <= 1'b1;
                                else        p1_win <= 1'b1;
                                phase <= PH_DONE;
                            end else begin
                                phase <= PH_SHOW;
                            end
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                    PH_SHOW: begin
                        if (last_plyr && tries2 == TRY_MAX) begin
                            draw  <= 1'b1;
                            phase <= PH_DONE;
                        end else begin
                            phase <= last_plyr ? PH_GUESS1 : PH_GUESS2;
                        end
                    end
                    default: phase <= PH_SET1;
                endcase
            end else if (expire) begin
                bulls     <= '0;
                cows      <= '0;
                last_plyr <= cur_p2;
                timeout   <= 1'b1;
                if (cur_p2) tries2 <= sat_inc(tries2);
                else        tries1 <= sat_inc(tries1);
                phase     <= PH_SHOW;
            end
        end
    end

endmodule

// File: tb/tb_bulls_cows_match.sv
// tb_bulls_cows_match: directed game scenarios plus random play, all checked
// against a command-level reference model of the referee.

module tb_bulls_cows_match;

    localparam int ND  = 4;
    localparam int DW  = 4;
    localparam int SYM = 10;
    localparam int MG  = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [15:0]   code_in;
    logic          enter;
    logic          abort;
    logic [2:0]    phase;
    logic [2:0]    bulls;
    logic [2:0]    cows;
    logic          last_plyr;
    logic [3:0]    tries1;
    logic [3:0]    tries2;
    logic          accept;
    logic          reject;
    logic          timeout;
    logic          p1_win;
    logic          p2_win;
    logic          draw;

    bulls_cows_match #(
        .NUM_DIGITS(ND), .DIGIT_W(DW), .SYMBOLS(SYM), .MAX_GUESSES(MG), .TURN_TIMEOUT(1000)
    ) dut (
        .clock(clock), .reset_n(reset_n), .code_in(code_in), .enter(enter), .abort(abort),
        .phase(phase), .bulls(bulls), .cows(cows), .last_plyr(last_plyr),
        .tries1(tries1), .tries2(tries2), .accept(accept), .reject(reject),
        .timeout(timeout), .p1_win(p1_win), .p2_win(p2_win), .draw(draw)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- reference model (one step per command) ----------------
    int          m_phase;
    logic [15:0] m_sec [2];
    int          m_bulls, m_cows, m_last;
    int          m_tries [2];
    int          m_win [2];
    int          m_draw, m_acc, m_rej;

    function automatic int digit(input logic [15:0] c, input int k);
        return int'(c[k*4 +: 4]);
    endfunction

    function automatic bit model_valid(input logic [15:0] c);
        int seen [16];
        foreach (seen[s]) seen[s] = 0;
        for (int k = 0; k < ND; k++) begin
            if (digit(c, k) >= SYM) return 1'b0;
            seen[digit(c, k)]++;
            if (seen[digit(c, k)] > 1) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit has_sym(input logic [15:0] c, input int s);
        for (int k = 0; k < ND; k++) if (digit(c, k) == s) return 1'b1;
        return 1'b0;
    endfunction

    // bulls = positional matches; cows = shared symbols minus bulls.
    task automatic model_score(input logic [15:0] s, input logic [15:0] g, output int b, output int cw);
        int common;
        b = 0;
        common = 0;
        for (int k = 0; k < ND; k++) if (digit(s, k) == digit(g, k)) b++;
        for (int v = 0; v < SYM; v++) if (has_sym(s, v) && has_sym(g, v)) common++;
        cw = common - b;
    endtask

    task automatic model_clear();
        m_phase = 0; m_sec[0] = '0; m_sec[1] = '0;
        m_bulls = 0; m_cows = 0; m_last = 0;
        m_tries[0] = 0; m_tries[1] = 0; m_win[0] = 0; m_win[1] = 0;
        m_draw = 0; m_acc = 0; m_rej = 0;
    endtask

    task automatic model_enter(input logic [15:0] c);
        int p, b, cw;
        m_acc = 0;
        m_rej = 0;
        case (m_phase)
            0, 1: begin
                if (model_valid(c)) begin
                    m_sec[m_phase] = c; m_acc = 1; m_phase++;
                end else m_rej = 1;
            end
            2, 3: begin
                p = m_phase - 2;
                if (model_valid(c)) begin
                    model_score(m_sec[1-p], c, b, cw);
                    m_bulls = b; m_cows = cw; m_last = p; m_acc = 1;
                    if (m_tries[p] < MG) m_tries[p]++;
                    if (b == ND) begin m_win[p] = 1; m_phase = 5; end
                    else m_phase = 4;
                end else m_rej = 1;
            end
            4: begin
                if (m_last == 1 && m_tries[1] == MG) begin m_draw = 1; m_phase = 5; end
                else m_phase = (m_last == 1) ? 2 : 3;
            end
            default: model_clear();
        endcase
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".phase"},  32'(phase),     32'(m_phase));
        check({ctx, ".bulls"},  32'(bulls),     32'(m_bulls));
        check({ctx, ".cows"},   32'(cows),      32'(m_cows));
        check({ctx, ".last"},   32'(last_plyr), 32'(m_last));
        check({ctx, ".tries1"}, 32'(tries1),    32'(m_tries[0]));
        check({ctx, ".tries2"}, 32'(tries2),    32'(m_tries[1]));
        check({ctx, ".accept"}, 32'(accept),    32'(m_acc));
        check({ctx, ".reject"}, 32'(reject),    32'(m_rej));
        check({ctx, ".timeout"},32'(timeout),   32'd0);
        check({ctx, ".p1_win"}, 32'(p1_win),    32'(m_win[0]));
        check({ctx, ".p2_win"}, 32'(p2_win),    32'(m_win[1]));
        check({ctx, ".draw"},   32'(draw),      32'(m_draw));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [15:0] c, input string ctx);
        @(negedge clock);
        code_in = c;
        enter   = 1'b1;
        model_enter(c);
        @(posedge clock); #1;
        check_all(ctx);
        @(negedge clock);
        enter = 1'b0;
        m_acc = 0;
        m_rej = 0;
        @(posedge clock); #1;
        check_all({ctx, ".after"});
    endtask

    task automatic do_abort(input bit with_enter, input string ctx);
        @(negedge clock);
        abort   = 1'b1;
        enter   = with_enter;
        code_in = 16'h1234;
        model_clear();
        @(posedge clock); #1;
        check_all(ctx);
        @(negedge clock);
        abort = 1'b0;
        enter = 1'b0;
        @(posedge clock); #1;
        check_all({ctx, ".after"});
    endtask

    function automatic logic [15:0] rand_valid();
        int pool [10];
        int j, t;
        logic [15:0] c;
        for (int i = 0; i < 10; i++) pool[i] = i;
        for (int i = 9; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = pool[i]; pool[i] = pool[j]; pool[j] = t;
        end
        c = '0;
        for (int k = 0; k < ND; k++) c[k*4 +: 4] = 4'(pool[k]);
        return c;
    endfunction

    function automatic logic [15:0] rand_invalid();
        logic [15:0] c;
        int k;
        c = rand_valid();
        k = $urandom_range(0, ND - 1);
        if ($urandom_range(0, 1) == 0) c[k*4 +: 4] = 4'($urandom_range(SYM, 15));
        else c[((k + 1) % ND)*4 +: 4] = c[k*4 +: 4];
        return c;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] c;
        int r;

        // Reset with enter held high through release: no command may result.
        reset_n = 1'b0;
        enter   = 1'b1;
        abort   = 1'b0;
        code_in = 16'h1234;
        model_clear();
        #23;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_all("reset_held_enter");
        @(negedge clock);
        enter = 1'b0;
        @(posedge clock); #1;
        check_all("reset");

        // Basic scoring.
        press(16'h1234, "t1.set1");
        press(16'h5678, "t1.set2");
        press(16'h5687, "t1.guess");
        check("t1.bulls_const", 32'(bulls), 32'd2);
        check("t1.cows_const",  32'(cows),  32'd2);
        check("t1.tries1_const",32'(tries1),32'd1);
        check("t1.phase_const", 32'(phase), 32'd4);

        // Illegal secrets.
        do_abort(1'b0, "t2.abort");
        press(16'h1123, "t2.dup");
        press(16'h12A4, "t2.sym");
        check("t2.phase_const", 32'(phase), 32'd0);

        // First-turn win.
        press(16'h1234, "t3.set1");
        press(16'h5678, "t3.set2");
        press(16'h5678, "t3.hit");
        check("t3.p1_win_const", 32'(p1_win), 32'd1);
        check("t3.phase_const",  32'(phase),  32'd5);
        check("t3.tries2_const", 32'(tries2), 32'd0);
        press(16'h9876, "t3.done_frozen_guess");

        // Full budget without hits ends in a draw.
        press(16'h1234, "t4.set1");
        press(16'h5678, "t4.set2");
        for (int i = 0; i < MG; i++) begin
            press(16'h1234, "t4.g1");
            press(16'h0000, "t4.s1");
            press(16'h5678, "t4.g2");
            press(16'h0000, "t4.s2");
        end
        check("t4.draw_const",   32'(draw),   32'd1);
        check("t4.phase_const",  32'(phase),  32'd5);
        check("t4.tries2_const", 32'(tries2), 32'(MG));
        press(16'h1234, "t4.restart");

        // Abort in GUESS2, with a simultaneous enter rise.
        press(16'h1234, "t5.set1");
        press(16'h5678, "t5.set2");
        press(16'h9012, "t5.g1");
        press(16'h0000, "t5.show");
        check("t5.phase_guess2", 32'(phase), 32'd3);
        do_abort(1'b1, "t5.abort");
        check("t5.tries1_const", 32'(tries1), 32'd0);

        // Random play.
        for (int step = 0; step < 600; step++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_abort(1'($urandom_range(0, 1)), "rnd.abort");
            end else begin
                r = $urandom_range(0, 99);
                if ((m_phase == 2 || m_phase == 3) && r < 8) c = m_sec[3 - m_phase];
                else if (r < 30) c = rand_invalid();
                else c = rand_valid();
                press(c, "rnd.press");
            end
        end

        // Async reset mid-game.
        press(16'h1234, "t6.set1");
        #3 reset_n = 1'b0;
        model_clear();
        #1;
        check_all("t6.async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_all("t6.released");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
